// File: rtl/pn_gen.sv
`timescale 1ns/1ps
// pn_gen: 12-bit maximal-length Fibonacci LFSR PN-sequence generator.
// Polynomial x^12 + x^6 + x^4 + x + 1, period 4095. One chip per clock on
// pn_out, with a one-cycle pulse on pn_roll each time the register returns to SEED.
// Optional feature macro: PN_GEN_LOCKUP_RECOVER_EN. When defined, an all-zero
// register (upset or forced) reloads SEED on the next edge. When undefined, the
// all-zero state is left alone and persists.
module pn_gen #(
  parameter logic [11:0] SEED = 12'hFFF
) (
  input  logic        clock,
  input  logic        reset,
  output logic        pn_out,
  output logic        pn_roll,
  output logic [11:0] state
);

  logic [11:0] state_q;
  logic [11:0] state_d;
  logic        roll_q;
  logic        roll_d;
  logic        fb;

  // An all-zero seed would lock the LFSR at zero, so it is rejected at elaboration.
  if (SEED == 12'h000) begin : gSeedCheck
    $error("pn_gen: SEED must be nonzero");
  end

  // Next state shifts toward the MSB, with the tap parity entering bit 0; roll flags the return to SEED.
  always_comb begin
    fb      = state_q[11] ^ state_q[5] ^ state_q[3] ^ state_q[0];
    state_d = {state_q[10:0], fb};
`ifdef PN_GEN_LOCKUP_RECOVER_EN
    if (state_q == 12'h000) begin
      state_d = SEED;
    end
`endif
    roll_d  = (state_d == SEED);
  end

  // Register the state and the wrap pulse; reset is asynchronous and reloads SEED.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= SEED;
      roll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      roll_q  <= roll_d;
    end
  end

  assign state   = state_q;
  assign pn_out  = state_q[11];
  assign pn_roll = roll_q;

endmodule

// File: tb/tb_pn_gen.sv
`timescale 1ns/1ps
// tb_pn_gen: randomized self-checking bench for pn_gen.
// Two instances are used: one with the default SEED (12'hFFF) and one with SEED = 12'h001.
// Expected sequences are precomputed from the polynomial. During checking, an
// expected value is looked up by its edge count since reset release.
module tb_pn_gen;

  localparam int          PERIOD = 4095;
  localparam logic [11:0] SEED_A = 12'hFFF;
  localparam logic [11:0] SEED_B = 12'h001;
  localparam int          TAPS [4] = '{12, 6, 4, 1};

  logic        clock;
  logic        reset;
  logic        pnOutA;
  logic        pnRollA;
  logic [11:0] stateA;
  logic        pnOutB;
  logic        pnRollB;
  logic [11:0] stateB;

  int          compareCount;
  int          mismatchCount;
  int          edges;
  int          onesCount;
  int          dupCount;
  bit          seen [4096];
  logic [11:0] seqA [PERIOD];
  logic [11:0] seqB [PERIOD];

  pn_gen #(.SEED(SEED_A)) dut (
    .clock   (clock),
    .reset   (reset),
    .pn_out  (pnOutA),
    .pn_roll (pnRollA),
    .state   (stateA)
  );

  pn_gen #(.SEED(SEED_B)) dutB (
    .clock   (clock),
    .reset   (reset),
    .pn_out  (pnOutB),
    .pn_roll (pnRollB),
    .state   (stateB)
  );

  // 20 ns clock.
  always #10 clock = ~clock;

  // Watchdog so the run always ends.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, edges=%0d", edges);
    $fatal(1, "[TB] watchdog expired");
  end

  // One polynomial step: exponent e of x^e taps register bit e-1.
  function automatic logic [11:0] polyStep(input logic [11:0] s);
    logic fbit;
    fbit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fbit = fbit ^ s[TAPS[i] - 1];
    end
    return {s[10:0], fbit};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", tag, edges, observed, expected);
    end
  endtask

  task automatic clearStats();
    onesCount = 0;
    dupCount  = 0;
    foreach (seen[i]) seen[i] = 1'b0;
  endtask

  task automatic checkB();
    int idx;
    idx = edges % PERIOD;
    checkOutput("stateB", {20'd0, stateB}, {20'd0, seqB[idx]});
    checkOutput("pnOutB", {31'd0, pnOutB}, {31'd0, seqB[idx][11]});
    checkOutput("pnRollB", {31'd0, pnRollB}, {31'd0, (edges > 0 && idx == 0)});
  endtask

  task automatic checkA();
    int idx;
    idx = edges % PERIOD;
    checkOutput("stateA", {20'd0, stateA}, {20'd0, seqA[idx]});
    checkOutput("pnOutA", {31'd0, pnOutA}, {31'd0, seqA[idx][11]});
    checkOutput("pnRollA", {31'd0, pnRollA}, {31'd0, (edges > 0 && idx == 0)});
  endtask

  // Advance n edges, checking both instances and per-period statistics of instance A.
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
      edges++;
      checkA();
      checkB();
      if (edges == 1) checkOutput("step1", {20'd0, stateA}, 32'h0000_0FFE);
      if (edges == 2) checkOutput("step2", {20'd0, stateA}, 32'h0000_0FFD);
      onesCount += int'(pnOutA);
      if (seen[stateA]) dupCount++;
      seen[stateA] = 1'b1;
      if (edges % PERIOD == 0) begin
        checkOutput("onesPerPeriod", onesCount, 2048);
        checkOutput("repeatsInPeriod", dupCount, 0);
        clearStats();
      end
    end
  endtask

  // Assert reset mid-cycle and check that it takes effect before any clock edge.
  task automatic asyncReset();
    int hold;
    #4;
    reset = 1'b0;
    #1;
    checkOutput("asyncStateA", {20'd0, stateA}, {20'd0, SEED_A});
    checkOutput("asyncRollA", {31'd0, pnRollA}, 32'd0);
    checkOutput("asyncPnOutA", {31'd0, pnOutA}, 32'd1);
    checkOutput("asyncStateB", {20'd0, stateB}, {20'd0, SEED_B});
    hold = int'($urandom_range(1, 3));
    for (int k = 0; k < hold; k++) begin
      @(posedge clock);
      #1;
      checkOutput("holdStateA", {20'd0, stateA}, {20'd0, SEED_A});
      checkOutput("holdRollA", {31'd0, pnRollA}, 32'd0);
    end
  endtask

  task automatic releaseReset();
    @(negedge clock);
    reset = 1'b1;
    edges = 0;
    clearStats();
    #1;
    checkOutput("releaseStateA", {20'd0, stateA}, {20'd0, SEED_A});
    checkOutput("releaseRollA", {31'd0, pnRollA}, 32'd0);
    checkOutput("releaseStateB", {20'd0, stateB}, {20'd0, SEED_B});
    checkOutput("releaseRollB", {31'd0, pnRollB}, 32'd0);
  endtask

  // Main sequence: reset, four full periods, async resets at fixed and random points, lockup.
  initial begin
    logic [11:0] s;
    compareCount  = 0;
    mismatchCount = 0;
    edges         = 0;
    clearStats();

    s = SEED_A;
    for (int i = 0; i < PERIOD; i++) begin
      seqA[i] = s;
      s = polyStep(s);
    end
    s = SEED_B;
    for (int i = 0; i < PERIOD; i++) begin
      seqB[i] = s;
      s = polyStep(s);
    end

    clock = 1'b0;
    reset = 1'b1;
    #5;
    reset = 1'b0;
    #6;
    checkOutput("resetStateA", {20'd0, stateA}, 32'h0000_0FFF);
    checkOutput("resetPnOutA", {31'd0, pnOutA}, 32'd1);
    checkOutput("resetRollA", {31'd0, pnRollA}, 32'd0);
    checkOutput("resetStateB", {20'd0, stateB}, 32'h0000_0001);
    checkOutput("resetRollB", {31'd0, pnRollB}, 32'd0);
    #14;
    reset = 1'b1;
    edges = 0;
    clearStats();
    #1;
    checkOutput("firstCycleStateA", {20'd0, stateA}, 32'h0000_0FFF);
    checkOutput("firstCycleRollA", {31'd0, pnRollA}, 32'd0);

    applyStimulus(4 * PERIOD);

    asyncReset();
    releaseReset();
    applyStimulus(1000);
    asyncReset();
    releaseReset();
    applyStimulus(PERIOD);
    checkOutput("pulseBeforeReset", {31'd0, pnRollA}, 32'd1);
    asyncReset();
    releaseReset();

    for (int r = 0; r < 3; r++) begin
      applyStimulus(int'($urandom_range(1, PERIOD - 1)));
      asyncReset();
      releaseReset();
    end
    applyStimulus(PERIOD);

    applyStimulus(5);
    @(negedge clock);
    force dut.state_q = 12'h000;
    #1;
    release dut.state_q;
    #1;
    checkOutput("lockForcedState", {20'd0, stateA}, 32'd0);
    checkOutput("lockForcedPnOut", {31'd0, pnOutA}, 32'd0);
    @(posedge clock);
    #1;
    edges++;
    checkB();
`ifdef PN_GEN_LOCKUP_RECOVER_EN
    checkOutput("lockRecoverState", {20'd0, stateA}, {20'd0, SEED_A});
    checkOutput("lockRecoverRoll", {31'd0, pnRollA}, 32'd1);
    @(posedge clock);
    #1;
    edges++;
    checkB();
    checkOutput("lockAfterState", {20'd0, stateA}, 32'h0000_0FFE);
    checkOutput("lockAfterRoll", {31'd0, pnRollA}, 32'd0);
`else
    checkOutput("lockStuckState", {20'd0, stateA}, 32'd0);
    checkOutput("lockStuckRoll", {31'd0, pnRollA}, 32'd0);
    @(posedge clock);
    #1;
    edges++;
    checkB();
    checkOutput("lockStillState", {20'd0, stateA}, 32'd0);
    checkOutput("lockStillPnOut", {31'd0, pnOutA}, 32'd0);
    checkOutput("lockStillRoll", {31'd0, pnRollA}, 32'd0);
`endif
    asyncReset();
    releaseReset();
    applyStimulus(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
